boreal_ledger_target: RTL

// - Slave-side responder on the interconnect ledger port (0x1005_0000-0x1005_FFFF); completes sel/ack transactions.
// - Append-only audit log: privileged writes append 32-bit records; readback by index, running digest, seal lock.
// - Inputs are the ledger_* outputs of boreal_interconnect; rdata/ack return to its ledger_rdata/ledger_ack.

---
 rtl/boreal_pkg.sv | 23 ++
 rtl/boreal_ledger_ram.sv | 20 ++
 rtl/boreal_ledger_target.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/boreal_pkg.sv
// Shared ledger-port constants, FSM encoding and the digest rotate helper.
package boreal_pkg;

  localparam logic [15:0] LEDGER_BASE        = 16'h1005;
  localparam logic [15:0] LEDGER_OFF_CTRL    = 16'h0000;
  localparam logic [15:0] LEDGER_OFF_STATUS  = 16'h0004;
  localparam logic [15:0] LEDGER_OFF_SEQ     = 16'h0008;
  localparam logic [15:0] LEDGER_OFF_APPEND  = 16'h000C;
  localparam logic [15:0] LEDGER_OFF_DIGEST  = 16'h0010;
  localparam logic [15:0] LEDGER_OFF_REJECTS = 16'h0014;
  localparam logic [15:0] LEDGER_ENTRY_BASE  = 16'h0100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } ledger_state_t;

  function automatic logic [31:0] rotl5(input logic [31:0] v);
    return {v[26:0], v[31:27]};
  endfunction

endpackage

// File: rtl/boreal_ledger_ram.sv
// Log storage: DEPTH x 32 single-port RAM, synchronous write, registered read.
module boreal_ledger_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/boreal_ledger_target.sv
// Ledger-port slave: sel/ack responder in front of an append-only audit log.
//   state   | meaning
//   ST_IDLE | waiting for sel; request fields latched on exit
//   ST_WAIT | counting extra wait cycles before completion
//   ST_ACK  | one-cycle ack; side effects commit here
module boreal_ledger_target
  import boreal_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0,
  parameter int OVERWRITE   = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ledger_sel,
  input  logic        ledger_wr,
  input  logic [31:0] ledger_addr,
  input  logic [31:0] ledger_wdata,
  output logic [31:0] ledger_rdata,
  output logic        ledger_ack
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [2:0]  WAIT_LOAD  = 3'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
  localparam logic [16:0] ENTRY_END  = 17'(LEDGER_ENTRY_BASE) + 17'(4 * DEPTH);
  localparam logic [13:0] ENTRY_WORD = 14'(LEDGER_ENTRY_BASE >> 2);

  ledger_state_t state, state_nxt;
  logic [2:0]    wcnt, wcnt_nxt;
  logic [15:0]   off_q;
  logic          wr_q;
  logic [31:0]   wdata_q;

  logic [AW:0]   count;
  logic [AW-1:0] wr_ptr, rd_base;
  logic [31:0]   seq, digest;
  logic [15:0]   rejects;
  logic          sealed, overflow;

  logic [15:0]   rd_off;
  logic [13:0]   rd_idx, ent_idx;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_q, rd_mux;
  logic          full, commit_wr, is_append, accept, reject;

  function automatic logic is_entry(input logic [15:0] o);
    return (o >= LEDGER_ENTRY_BASE) && (17'(o) < ENTRY_END);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      wcnt    <= '0;
      off_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      if (state == ST_IDLE && ledger_sel) begin
        off_q   <= {ledger_addr[15:2], 2'b00};
        wr_q    <= ledger_wr;
        wdata_q <= ledger_wdata;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    case (state)
      ST_IDLE: if (ledger_sel) begin
        if (WAIT_STATES == 0) state_nxt = ST_ACK;
        else begin
          state_nxt = ST_WAIT;
          wcnt_nxt  = WAIT_LOAD;
        end
      end
      ST_WAIT: if (wcnt == 3'd0) state_nxt = ST_ACK;
               else wcnt_nxt = wcnt - 3'd1;
      ST_ACK:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Read address comes straight off the bus in IDLE so the registered RAM
  // output is ready by ACK even with no wait states; ACK owns the port for writes.
  assign rd_off   = (state == ST_IDLE) ? {ledger_addr[15:2], 2'b00} : off_q;
  assign rd_idx   = rd_off[15:2] - ENTRY_WORD;
  assign ent_idx  = off_q[15:2] - ENTRY_WORD;
  assign ram_addr = (state == ST_ACK) ? wr_ptr : rd_base + rd_idx[AW-1:0];

  assign full      = (count == FULL_COUNT);
  assign commit_wr = (state == ST_ACK) && wr_q;
  assign is_append = commit_wr && (off_q == LEDGER_OFF_APPEND);
  assign accept    = is_append && !sealed && (!full || OVERWRITE != 0);
  assign reject    = commit_wr &&
                     ((off_q == LEDGER_OFF_APPEND && (sealed || (full && OVERWRITE == 0))) ||
                      (off_q == LEDGER_OFF_CTRL && wdata_q[1] && sealed) ||
                      off_q == LEDGER_OFF_STATUS || off_q == LEDGER_OFF_SEQ ||
                      off_q == LEDGER_OFF_DIGEST || off_q == LEDGER_OFF_REJECTS ||
                      is_entry(off_q));

  boreal_ledger_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (accept),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      wr_ptr   <= '0;
      rd_base  <= '0;
      seq      <= '0;
      digest   <= '0;
      rejects  <= '0;
      sealed   <= 1'b0;
      overflow <= 1'b0;
    end else if (commit_wr) begin
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
        seq    <= seq + 32'd1;
        digest <= rotl5(digest) ^ wdata_q ^ seq;
        if (full) rd_base <= rd_base + 1'b1;
        else      count   <= count + 1'b1;
      end
      if (is_append && !sealed && full) overflow <= 1'b1;
      if (reject && rejects != 16'hFFFF) rejects <= rejects + 16'd1;
      if (off_q == LEDGER_OFF_CTRL) begin
        if (wdata_q[1] && !sealed) begin
          count    <= '0;
          wr_ptr   <= '0;
          rd_base  <= '0;
          overflow <= 1'b0;
        end
        if (wdata_q[0]) sealed <= 1'b1;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    if (is_entry(off_q)) begin
      if (ent_idx < 14'(count)) rd_mux = ram_q;
    end else begin
      case (off_q)
        LEDGER_OFF_CTRL:    rd_mux = {30'b0, sealed, 1'b0};
        LEDGER_OFF_STATUS:  rd_mux = {13'b0, overflow, sealed, full, 7'b0, 9'(count)};
        LEDGER_OFF_SEQ:     rd_mux = seq;
        LEDGER_OFF_DIGEST:  rd_mux = digest;
        LEDGER_OFF_REJECTS: rd_mux = {16'b0, rejects};
        default:            rd_mux = '0;
      endcase
    end
  end

  assign ledger_ack   = (state == ST_ACK);
  assign ledger_rdata = (state == ST_ACK && !wr_q) ? rd_mux : '0;

  logic unused_bits;
  assign unused_bits = ^{ledger_addr[31:16], ledger_addr[1:0], rd_idx[13:AW]};

endmodule
